// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem read, ISSUE/WAIT/HOLD cycle,
// redirect with misalignment trap into a sticky FAULT state.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_data_in,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fault,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] S_ISSUE = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        fault_q, fault_d;
   logic [31:0] cnt_q, cnt_d;

   logic redir_ok;
   logic redir_bad;
   logic hs;

   assign redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
   assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
   assign hs        = (state_q == S_HOLD) & instr_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;
      // FAULT is absorbing; only reset leaves it.
      if (state_q != S_FAULT) begin
         if (redir_bad) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
         end else if (redir_ok) begin
            pc_d    = redirect_pc;
            state_d = S_ISSUE;
         end else begin
            case (state_q)
               S_ISSUE: state_d = S_WAIT;
               S_WAIT: begin
                  instr_d = imem_data_in;
                  ipc_d   = pc_q;
                  state_d = S_HOLD;
               end
               S_HOLD: begin
                  if (hs) begin
                     pc_d    = pc_q + 32'd4;
                     cnt_d   = cnt_q + 32'd1;
                     state_d = S_ISSUE;
                  end
               end
               default: state_d = state_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_ISSUE;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         ipc_q   <= RESET_PC;
         fault_q <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_address = pc_q;
   assign instr        = instr_q;
   assign instr_pc     = ipc_q;
   assign instr_valid  = (state_q == S_HOLD);
   assign fault        = fault_q;
   assign fetch_count  = cnt_q;

endmodule
